// File: rtl/ula_op_sequencer.sv
// ula_op_sequencer
//   Operand sequencer and result-capture stage in front of a combinational ULA
//   (add/sub with overflow). Operands arrive one beat at a time, are held in
//   registers that drive the ULA, and the ULA result is registered and offered
//   on an output port. Chain mode reuses the previous result as operand A, so
//   the block behaves as an accumulator.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high. A source that sees ready low must hold valid and its data
//   unchanged until the transfer happens. ready never depends on valid.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   clear                 sync clear of ovf_sticky, op_count, accumulator valid
//   in_valid/in_ready     operand beat handshake; in_data operand value
//   in_sel                0 = A+B, 1 = A-B (taken on the B / chain beat)
//   in_chain              taken in IDLE: 1 = A comes from accumulator
//   ula_a/ula_b/ula_sel   registered ULA operands and op select
//   ula_s/ula_ovf         ULA result and overflow
//   out_valid/out_ready   result handshake; out_result/out_ovf captured result
//   ovf_sticky            OR of all captured overflows since reset/clear
//   op_count              completed operations, saturating at 255
//   dbg_state             current FSM state (0 IDLE, 1 WAIT_B, 2 EXEC, 3 DONE)
module ula_op_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_chain,
    output logic [WIDTH-1:0] ula_a,
    output logic [WIDTH-1:0] ula_b,
    output logic             ula_sel,
    input  logic [WIDTH-1:0] ula_s,
    input  logic             ula_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_ovf,
    output logic             ovf_sticky,
    output logic [7:0]       op_count,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_B = 2'd1,
        EXEC   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ula_a_q, ula_a_d;
    logic [WIDTH-1:0] ula_b_q, ula_b_d;
    logic             ula_sel_q, ula_sel_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic             out_ovf_q, out_ovf_d;
    logic             ovf_sticky_q, ovf_sticky_d;
    logic [7:0]       op_count_q, op_count_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             acc_valid_q, acc_valid_d;
    logic             beat;

    assign in_ready  = (state_q == IDLE) || (state_q == WAIT_B);
    assign out_valid = (state_q == DONE);
    assign beat      = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        ula_a_d      = ula_a_q;
        ula_b_d      = ula_b_q;
        ula_sel_d    = ula_sel_q;
        out_result_d = out_result_q;
        out_ovf_d    = out_ovf_q;
        ovf_sticky_d = ovf_sticky_q;
        op_count_d   = op_count_q;
        acc_d        = acc_q;
        acc_valid_d  = acc_valid_q;

        case (state_q)
            IDLE: begin
                if (beat) begin
                    if (in_chain) begin
                        // With no result since reset/clear the accumulator reads as zero.
                        ula_a_d   = acc_valid_q ? acc_q : '0;
                        ula_b_d   = in_data;
                        ula_sel_d = in_sel;
                        state_d   = EXEC;
                    end else begin
                        ula_a_d = in_data;
                        state_d = WAIT_B;
                    end
                end
            end
            WAIT_B: begin
                if (beat) begin
                    ula_b_d   = in_data;
                    ula_sel_d = in_sel;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                // The ULA has had the whole cycle to settle on the registered operands.
                out_result_d = ula_s;
                out_ovf_d    = ula_ovf;
                acc_d        = ula_s;
                acc_valid_d  = 1'b1;
                ovf_sticky_d = ovf_sticky_q | ula_ovf;
                if (op_count_q != 8'hFF) begin
                    op_count_d = op_count_q + 8'd1;
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // clear overrides the EXEC statistics update but leaves the captured result alone.
        if (clear) begin
            ovf_sticky_d = 1'b0;
            op_count_d   = 8'd0;
            acc_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ula_a_q      <= '0;
            ula_b_q      <= '0;
            ula_sel_q    <= 1'b0;
            out_result_q <= '0;
            out_ovf_q    <= 1'b0;
            ovf_sticky_q <= 1'b0;
            op_count_q   <= 8'd0;
            acc_q        <= '0;
            acc_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ula_a_q      <= ula_a_d;
            ula_b_q      <= ula_b_d;
            ula_sel_q    <= ula_sel_d;
            out_result_q <= out_result_d;
            out_ovf_q    <= out_ovf_d;
            ovf_sticky_q <= ovf_sticky_d;
            op_count_q   <= op_count_d;
            acc_q        <= acc_d;
            acc_valid_q  <= acc_valid_d;
        end
    end

    assign ula_a      = ula_a_q;
    assign ula_b      = ula_b_q;
    assign ula_sel    = ula_sel_q;
    assign out_result = out_result_q;
    assign out_ovf    = out_ovf_q;
    assign ovf_sticky = ovf_sticky_q;
    assign op_count   = op_count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ula_op_sequencer.sv
// Bench for ula_op_sequencer with a 4-bit add/sub ULA modelled in place.
module tb_ula_op_sequencer;
  localparam int W = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, clear, in_valid, in_ready, in_sel, in_chain;
  logic [W-1:0] in_data, ula_a, ula_b, ula_s, out_result;
  logic         ula_sel, ula_ovf, out_valid, out_ready, out_ovf, ovf_sticky;
  logic [7:0]   op_count;
  logic [1:0]   dbg_state;

  // ULA: unsigned add with carry-out, subtract with borrow-out
  assign {ula_ovf, ula_s} = ula_sel ? ({1'b0, ula_a} - {1'b0, ula_b})
                                    : ({1'b0, ula_a} + {1'b0, ula_b});

  ula_op_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_chain(in_chain),
    .ula_a(ula_a), .ula_b(ula_b), .ula_sel(ula_sel),
    .ula_s(ula_s), .ula_ovf(ula_ovf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_ovf(out_ovf),
    .ovf_sticky(ovf_sticky), .op_count(op_count), .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: transaction level
  int m_acc;
  bit m_acc_valid;
  bit m_sticky;
  int m_cnt;

  task automatic model_reset();
    m_acc = 0; m_acc_valid = 0; m_sticky = 0; m_cnt = 0;
  endtask

  task automatic model_clear();
    m_acc_valid = 0; m_sticky = 0; m_cnt = 0;
  endtask

  task automatic model_op(input bit chain, input int a, input int b, input bit sel,
                          output int a_eff, output int res, output bit ovf);
    a_eff = chain ? (m_acc_valid ? m_acc : 0) : a;
    if (sel) begin
      ovf = (a_eff < b);
      res = (a_eff - b + 16) % 16;
    end else begin
      ovf = (a_eff + b) > 15;
      res = (a_eff + b) % 16;
    end
    m_acc = res;
    m_acc_valid = 1;
    m_sticky = m_sticky | ovf;
    if (m_cnt < 255) m_cnt++;
  endtask

  // driver tasks
  task automatic send_beat(input logic [W-1:0] d, input logic s, input logic c);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_sel = s; in_chain = c;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("beat_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = $urandom_range(0, 15);
  endtask

  task automatic wait_valid();
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    check("latency", lat, 2);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_hs_state", dbg_state, 0);
    check("post_hs_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
  endtask

  task automatic run_op(input bit chain, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit sel, input int stall,
                        input int exp_a, input int exp_res, input bit exp_ovf,
                        input bit exp_sticky, input int exp_cnt);
    // in_sel on the A beat and in_chain on the B beat must be ignored
    if (!chain) begin
      send_beat(a, $urandom_range(0, 1), 1'b0);
      send_beat(b, sel, $urandom_range(0, 1));
    end else begin
      send_beat(b, sel, 1'b1);
    end
    wait_valid();
    check("ula_a", ula_a, exp_a);
    check("ula_b", ula_b, b);
    check("ula_sel", ula_sel, sel);
    check("out_result", out_result, exp_res);
    check("out_ovf", out_ovf, exp_ovf);
    check("ovf_sticky", ovf_sticky, exp_sticky);
    check("op_count", op_count, exp_cnt);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_result", out_result, exp_res);
      check("stall_ovf", out_ovf, exp_ovf);
      check("stall_in_ready", in_ready, 0);
    end
    handshake();
  endtask

  task automatic rand_op(input int stall_max);
    bit chain, sel, ovf;
    logic [W-1:0] a, b;
    int a_eff, res;
    chain = $urandom_range(0, 1);
    sel = $urandom_range(0, 1);
    a = $urandom_range(0, 15);
    b = $urandom_range(0, 15);
    model_op(chain, a, b, sel, a_eff, res, ovf);
    run_op(chain, a, b, sel, $urandom_range(0, stall_max), a_eff, res, ovf, m_sticky, m_cnt);
  endtask

  typedef struct {
    bit          chain;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit          sel;
    int          stall;
    int          exp_a;
    int          exp_res;
    bit          exp_ovf;
    bit          exp_sticky;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int a_eff, res;
    bit ovf;

    // chain right after reset, two-beat add, chain sub, carry, sticky hold, borrow
    vecs[0] = '{1, 0,  5, 0, 0, 0,  5, 0, 0, 1};
    vecs[1] = '{0, 3,  1, 0, 0, 3,  4, 0, 0, 2};
    vecs[2] = '{1, 0,  3, 1, 1, 4,  1, 0, 0, 3};
    vecs[3] = '{0, 15, 2, 0, 3, 15, 1, 1, 1, 4};
    vecs[4] = '{0, 3,  1, 0, 0, 3,  4, 0, 1, 5};
    vecs[5] = '{1, 0,  6, 1, 2, 4, 14, 1, 1, 6};

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    in_sel = 1'b0; in_chain = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_state", dbg_state, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_ula_a", ula_a, 0);
    check("rst_out_result", out_result, 0);
    check("rst_op_count", op_count, 0);
    check("rst_sticky", ovf_sticky, 0);

    // table-driven directed vectors
    for (int i = 0; i < 6; i++) begin
      model_op(vecs[i].chain, vecs[i].a, vecs[i].b, vecs[i].sel, a_eff, res, ovf);
      run_op(vecs[i].chain, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].stall,
             vecs[i].exp_a, vecs[i].exp_res, vecs[i].exp_ovf, vecs[i].exp_sticky, vecs[i].exp_cnt);
    end

    // reset while waiting for B: operation dropped, next beat is operand A
    send_beat(4'd9, 1'b0, 1'b0);
    @(negedge clk);
    check("wb_state", dbg_state, 1);
    check("wb_ula_a", ula_a, 9);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("wbrst_state", dbg_state, 0);
    check("wbrst_ula_a", ula_a, 0);
    check("wbrst_ula_b", ula_b, 0);
    check("wbrst_ula_sel", ula_sel, 0);
    check("wbrst_out_result", out_result, 0);
    check("wbrst_out_ovf", out_ovf, 0);
    check("wbrst_sticky", ovf_sticky, 0);
    check("wbrst_op_count", op_count, 0);
    check("wbrst_out_valid", out_valid, 0);
    send_beat(4'd6, 1'b0, 1'b0);
    check("wbrst_a_beat_state", dbg_state, 1);
    check("wbrst_a_beat_ula_a", ula_a, 6);
    send_beat(4'd2, 1'b0, 1'b0);
    model_op(0, 6, 2, 0, a_eff, res, ovf);
    wait_valid();
    check("wbrst_result", out_result, 8);
    check("wbrst_count", op_count, 1);
    handshake();

    // clear during EXEC: stats cleared, result still captured
    send_beat(4'd15, 1'b0, 1'b0);
    send_beat(4'd2, 1'b0, 1'b0);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_op(0, 15, 2, 0, a_eff, res, ovf);
    model_clear();
    @(negedge clk);
    check("clr_out_valid", out_valid, 1);
    check("clr_out_result", out_result, 1);
    check("clr_out_ovf", out_ovf, 1);
    check("clr_op_count", op_count, 0);
    check("clr_sticky", ovf_sticky, 0);
    handshake();
    // accumulator invalidated by clear: chain starts from zero
    model_op(1, 0, 3, 0, a_eff, res, ovf);
    run_op(1, 4'd0, 4'd3, 1'b0, 0, 0, 3, 0, 0, 1);

    // random phase without clear: drives op_count into saturation
    for (int i = 0; i < 270; i++) rand_op(1);
    check("sat_count", op_count, 255);

    // random phase with occasional clear in IDLE
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        model_clear();
        check("idle_clear_count", op_count, 0);
        check("idle_clear_sticky", ovf_sticky, 0);
      end
      rand_op(3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
